// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and load/store (LS).
// One transaction in flight: IDLE grants, BUSY waits for mem_ack_i or timeout, RESP acks the requester.
module mem_arbiter #(
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned MAX_LS_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        ls_req_i,
  input  logic        ls_wen_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  input  logic [3:0]  ls_wmask_i,
  output logic [31:0] ls_rdata_o,
  output logic        ls_ack_o,
  output logic        ls_hold_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [1:0]  state_dbg
);
  // Handshake: *_req_i is a level held with its fields until the one-cycle *_ack_o;
  // a request still high after the ack edge is seen in IDLE as a new request.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_BURST);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t      state;
  logic [3:0]  ls_streak;
  logic [7:0]  wait_cnt;
  logic        owner_ls;
  logic        grant_ls;
  logic        grant_if;
  logic        done;
  logic [31:0] resp_data;

  // LS normally wins; IF gets through once LS has won MAX_LS_BURST times in a row over it.
  always_comb begin
    grant_ls = ls_req_i && !(if_req_i && (ls_streak == STREAK_MAX));
    grant_if = if_req_i && !grant_ls;
  end

  // An ack on the final wait cycle still counts as a normal completion.
  assign done      = mem_ack_i || (wait_cnt == WAIT_LAST);
  assign resp_data = (mem_ack_i && !mem_wen_o) ? mem_rdata_i : 32'h0;
  assign ls_hold_o = ls_req_i & ~ls_ack_o;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ls_streak   <= '0;
      wait_cnt    <= '0;
      owner_ls    <= 1'b0;
      if_rdata_o  <= '0;
      if_ack_o    <= 1'b0;
      ls_rdata_o  <= '0;
      ls_ack_o    <= 1'b0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_wen_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wmask_o <= '0;
    end else begin
      if_ack_o <= 1'b0;
      ls_ack_o <= 1'b0;
      err_o    <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (grant_ls) begin
            state       <= BUSY;
            owner_ls    <= 1'b1;
            mem_req_o   <= 1'b1;
            mem_wen_o   <= ls_wen_i;
            mem_addr_o  <= ls_addr_i;
            mem_wdata_o <= ls_wdata_i;
            mem_wmask_o <= ls_wmask_i;
            if (!if_req_i) begin
              ls_streak <= '0;
            end else if (ls_streak != STREAK_MAX) begin
              ls_streak <= ls_streak + 4'd1;
            end
          end else if (grant_if) begin
            state       <= BUSY;
            owner_ls    <= 1'b0;
            mem_req_o   <= 1'b1;
            mem_wen_o   <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            mem_wmask_o <= '0;
            ls_streak   <= '0;
          end else begin
            ls_streak <= '0;
          end
        end
        BUSY: begin
          if (done) begin
            state     <= RESP;
            mem_req_o <= 1'b0;
            err_o     <= !mem_ack_i;
            if (owner_ls) begin
              ls_ack_o   <= 1'b1;
              ls_rdata_o <= resp_data;
            end else begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= resp_data;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers hold requests until acked, a memory responder
// plays back per-op delays/data, and a monitor compares each ack against the expected queue.
module tb_mem_arbiter;
  localparam int TO  = 16;
  localparam int MLB = 4;

  typedef struct {
    logic        is_ls;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          delay;
    logic [31:0] rdata;
  } op_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        ls_req_i;
  logic        ls_wen_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic [3:0]  ls_wmask_i;
  logic [31:0] ls_rdata_o;
  logic        ls_ack_o;
  logic        ls_hold_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic [1:0]  state_dbg;

  op_t         if_ops[$];
  op_t         ls_ops[$];
  op_t         mem_q[$];
  logic [33:0] exp_q[$];   // {is_ls, err, rdata} in predicted grant order
  int          checks = 0;
  int          errors = 0;
  logic        resp_en = 1'b1;
  logic        ack_inject = 1'b0;
  logic [31:0] last_if = 32'h0;
  logic [31:0] last_ls = 32'h0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO), .MAX_LS_BURST(MLB)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .ls_req_i(ls_req_i), .ls_wen_i(ls_wen_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_wmask_i(ls_wmask_i), .ls_rdata_o(ls_rdata_o), .ls_ack_o(ls_ack_o), .ls_hold_o(ls_hold_o),
    .err_o(err_o), .mem_req_o(mem_req_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, TO - 1));
    if (r == 6) return TO - 1;
    if (r == 7) return TO;
    return TO + 5;
  endfunction

  function automatic op_t make_ls(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] wmask, input int delay, input logic [31:0] rdata);
    op_t o;
    o.is_ls = 1'b1; o.wen = wen; o.addr = addr; o.wdata = wdata;
    o.wmask = wmask; o.delay = delay; o.rdata = rdata;
    return o;
  endfunction

  function automatic op_t make_if(input logic [31:0] addr, input int delay, input logic [31:0] rdata);
    op_t o;
    o.is_ls = 1'b0; o.wen = 1'b0; o.addr = addr; o.wdata = 32'h0;
    o.wmask = 4'h0; o.delay = delay; o.rdata = rdata;
    return o;
  endfunction

  task automatic drive_ls();
    int n;
    foreach (ls_ops[i]) begin
      ls_req_i   = 1'b1;
      ls_wen_i   = ls_ops[i].wen;
      ls_addr_i  = ls_ops[i].addr;
      ls_wdata_i = ls_ops[i].wdata;
      ls_wmask_i = ls_ops[i].wmask;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n == 1) check("ls_hold_waiting", 32'(ls_hold_o), 32'd1);
      end while (!ls_ack_o && n < 500);
      check("ls_ack_seen", 32'(ls_ack_o), 32'd1);
      if (!ls_ack_o) break;
    end
    ls_req_i   = 1'b0;
    ls_wen_i   = 1'($urandom_range(0, 1));
    ls_addr_i  = $urandom;
    ls_wdata_i = $urandom;
    ls_wmask_i = 4'($urandom);
  endtask

  task automatic drive_if();
    int n;
    foreach (if_ops[i]) begin
      if_req_i  = 1'b1;
      if_addr_i = if_ops[i].addr;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!if_ack_o && n < 500);
      check("if_ack_seen", 32'(if_ack_o), 32'd1);
      if (!if_ack_o) break;
    end
    if_req_i  = 1'b0;
    if_addr_i = $urandom;
  endtask

  // Predict grant order from the priority rule, queue expectations, then run both requesters.
  task automatic run_scenario();
    int  streak;
    int  i_if;
    int  i_ls;
    op_t o;
    streak = 0; i_if = 0; i_ls = 0;
    while (i_if < if_ops.size() || i_ls < ls_ops.size()) begin
      if (i_ls < ls_ops.size() && !(i_if < if_ops.size() && streak == MLB)) begin
        o = ls_ops[i_ls];
        i_ls++;
        streak = (i_if < if_ops.size()) ? ((streak < MLB) ? streak + 1 : streak) : 0;
      end else begin
        o = if_ops[i_if];
        i_if++;
        streak = 0;
      end
      mem_q.push_back(o);
      exp_q.push_back({o.is_ls, 1'(o.delay >= TO), ((o.delay < TO) && !o.wen) ? o.rdata : 32'h0});
    end
    fork
      drive_if();
      drive_ls();
    join
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    check("resp_drained", 32'(exp_q.size()), 32'd0);
    check("mem_drained", 32'(mem_q.size()), 32'd0);
    exp_q.delete();
    mem_q.delete();
    if_ops.delete();
    ls_ops.delete();
    repeat ($urandom_range(2, 4)) @(negedge clk);
  endtask

  initial begin : responder
    op_t m;
    int  busy_len;
    int  bad_req;
    int  bad_fld;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        mem_ack_i = ack_inject;
      end else if (mem_req_o) begin
        if (mem_q.size() == 0) begin
          check("mem_req_unexpected", 32'(mem_req_o), 32'd0);
        end else begin
          m = mem_q.pop_front();
          check("mem_addr", mem_addr_o, m.addr);
          check("mem_wen", 32'(mem_wen_o), 32'(m.wen));
          check("mem_wdata", mem_wdata_o, m.wdata);
          check("mem_wmask", 32'(mem_wmask_o), 32'(m.wmask));
          busy_len = (m.delay < TO) ? m.delay + 1 : TO;
          bad_req = 0;
          bad_fld = 0;
          for (int k = 0; k <= busy_len; k++) begin
            if (k > 0) @(negedge clk);
            if (mem_req_o !== (k < busy_len)) bad_req++;
            if (k < busy_len && (mem_addr_o !== m.addr || mem_wen_o !== m.wen ||
                mem_wdata_o !== m.wdata || mem_wmask_o !== m.wmask)) bad_fld++;
            mem_ack_i   = (k == m.delay);
            mem_rdata_i = (k == m.delay) ? m.rdata : $urandom;
          end
          check("mem_req_window", 32'(bad_req), 32'd0);
          check("mem_fields_stable", 32'(bad_fld), 32'd0);
          @(negedge clk);
          mem_ack_i = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (if_ack_o || ls_ack_o) begin
        if (exp_q.size() == 0) begin
          check("ack_unexpected", 32'(if_ack_o | ls_ack_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_owner", {30'h0, ls_ack_o, if_ack_o}, e[33] ? 32'h2 : 32'h1);
          check("err", 32'(err_o), 32'(e[32]));
          if (e[33]) begin
            check("ls_rdata", ls_rdata_o, e[31:0]);
            check("if_rdata_hold", if_rdata_o, last_if);
            check("ls_hold_on_ack", 32'(ls_hold_o), 32'd0);
            last_ls = e[31:0];
          end else begin
            check("if_rdata", if_rdata_o, e[31:0]);
            check("ls_rdata_hold", ls_rdata_o, last_ls);
            last_if = e[31:0];
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n_ls;
    int n_if;
    int n;
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = $urandom;
    ls_req_i = 1'b0; ls_wen_i = 1'b1; ls_addr_i = $urandom;
    ls_wdata_i = $urandom; ls_wmask_i = 4'hf;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_wen", 32'(mem_wen_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_wdata", mem_wdata_o, 32'h0);
    check("rst_mem_wmask", 32'(mem_wmask_o), 32'd0);
    check("rst_acks", {30'h0, if_ack_o, ls_ack_o}, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_if_rdata", if_rdata_o, 32'h0);
    check("rst_ls_rdata", ls_rdata_o, 32'h0);

    // Plain load, granted in the first cycle out of reset.
    ls_ops.push_back(make_ls(1'b0, 32'h100, 32'h0, 4'h0, 2, 32'hDEADBEEF));
    rst = 1'b0;
    fork
      run_scenario();
      begin
        @(negedge clk);
        check("first_grant", 32'(mem_req_o), 32'd1);
      end
    join

    // Store: memory returns garbage data which must not reach ls_rdata_o.
    ls_ops.push_back(make_ls(1'b1, 32'h204, 32'h12345678, 4'b0011, 1, 32'hFEEDF00D));
    run_scenario();
    // No ack at all: timeout with err.
    ls_ops.push_back(make_ls(1'b0, 32'h300, 32'h0, 4'h0, TO + 5, 32'hAAAA5555));
    run_scenario();
    // Ack arrives one cycle late, during RESP: still a timeout, late ack ignored.
    if_ops.push_back(make_if(32'h400, TO, 32'h0BADC0DE));
    run_scenario();
    // Ack on exactly the timeout cycle wins.
    if_ops.push_back(make_if(32'h404, TO - 1, 32'hC0FFEE11));
    run_scenario();
    // Both held: LS x4, IF, LS, LS, IF.
    for (int i = 0; i < 6; i++) ls_ops.push_back(make_ls(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'h0, 1, $urandom));
    for (int i = 0; i < 2; i++) if_ops.push_back(make_if(32'h2000 + 32'(4 * i), 0, $urandom));
    run_scenario();

    for (int s = 0; s < 24; s++) begin
      n_ls = int'($urandom_range(0, 7));
      n_if = int'($urandom_range(0, 3));
      if (n_ls == 0 && n_if == 0) n_ls = 1;
      for (int i = 0; i < n_ls; i++)
        ls_ops.push_back(make_ls(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                                 pick_delay(), $urandom));
      for (int i = 0; i < n_if; i++)
        if_ops.push_back(make_if($urandom, pick_delay(), $urandom));
      run_scenario();
    end

    // Reset while BUSY, then a stray memory ack right after: nothing may be acked.
    resp_en = 1'b0;
    ls_req_i = 1'b1; ls_wen_i = 1'b0; ls_addr_i = 32'h500;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req_o && n < 10);
    check("rst_test_busy", 32'(state_dbg), 32'd1);
    rst = 1'b1;
    ls_req_i = 1'b0;
    ack_inject = 1'b1;
    @(negedge clk);
    check("rst_abort_req", 32'(mem_req_o), 32'd0);
    check("rst_abort_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_ack", {30'h0, if_ack_o, ls_ack_o}, 32'd0);
    check("rst_no_err", 32'(err_o), 32'd0);
    check("rst_idle_state", 32'(state_dbg), 32'd0);
    check("rst_idle_req", 32'(mem_req_o), 32'd0);
    check("rst_ls_rdata_clr", ls_rdata_o, 32'h0);
    ack_inject = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_after_no_ack", {30'h0, if_ack_o, ls_ack_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
